// File: rtl/matrix_op_conv_nk.sv
`default_nettype none
// ============================================================================
// Module      : matrix_op_conv_nk
// Description : Generalised 2-D convolution engine on a shared BRAM port.
//               Odd kernel 1..KMAX (cached on-chip), stride 1..3, "same"
//               (zero pad) or "valid" mode, signed/unsigned elements and
//               saturating or wrapping results.
// Ports       : clk, rst_n (async, active-low); start/done/busy/error
//               handshake; dim_m/dim_n/k_size/stride/pad_valid/signed_en/
//               sat_en configuration; addr_op1 (image), addr_op2 (kernel),
//               addr_res (result) bases; out_m/out_n result dims;
//               mem_rd_* (1-cycle read latency) and mem_wr_* memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_op_conv_nk #(
    parameter int ELEMENT_WIDTH = 8,
    parameter int ADDR_WIDTH    = 10,
    parameter int DIM_WIDTH     = 4,
    parameter int KMAX          = 5,
    parameter int ACC_WIDTH     = 2*ELEMENT_WIDTH+6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     done,
    output logic                     busy,
    output logic                     error,
    input  logic [DIM_WIDTH-1:0]     dim_m,
    input  logic [DIM_WIDTH-1:0]     dim_n,
    input  logic [2:0]               k_size,
    input  logic [1:0]               stride,
    input  logic                     pad_valid,
    input  logic                     signed_en,
    input  logic                     sat_en,
    input  logic [ADDR_WIDTH-1:0]    addr_op1,
    input  logic [ADDR_WIDTH-1:0]    addr_op2,
    input  logic [ADDR_WIDTH-1:0]    addr_res,
    output logic [DIM_WIDTH-1:0]     out_m,
    output logic [DIM_WIDTH-1:0]     out_n,
    output logic                     mem_rd_en,
    output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
    input  logic [ELEMENT_WIDTH-1:0] mem_rd_data,
    output logic                     mem_wr_en,
    output logic [ADDR_WIDTH-1:0]    mem_wr_addr,
    output logic [ELEMENT_WIDTH-1:0] mem_wr_data
);

    localparam int CDEPTH = KMAX*KMAX;
    localparam int CW     = $clog2(CDEPTH);
    // Signed tap coordinate with headroom for oi*stride+ki before pad removal
    localparam int RW     = DIM_WIDTH+4;

    localparam logic [3:0] c_IDLE     = 4'd0;
    localparam logic [3:0] c_CHECK    = 4'd1;
    localparam logic [3:0] c_LOAD_K   = 4'd2;
    localparam logic [3:0] c_WAIT_K   = 4'd3;
    localparam logic [3:0] c_PIX_INIT = 4'd4;
    localparam logic [3:0] c_TAP      = 4'd5;
    localparam logic [3:0] c_RD_WAIT  = 4'd6;
    localparam logic [3:0] c_MAC      = 4'd7;
    localparam logic [3:0] c_NEXT_TAP = 4'd8;
    localparam logic [3:0] c_WRITE    = 4'd9;
    localparam logic [3:0] c_NEXT_PIX = 4'd10;
    localparam logic [3:0] c_DONE     = 4'd11;

    localparam logic [ACC_WIDTH-1:0] c_SMAX = ACC_WIDTH'((1 << (ELEMENT_WIDTH-1)) - 1);
    localparam logic [ACC_WIDTH-1:0] c_SMIN = ~c_SMAX;
    localparam logic [ACC_WIDTH-1:0] c_UMAX = ACC_WIDTH'((1 << ELEMENT_WIDTH) - 1);

    logic [3:0]               r_state;
    logic [DIM_WIDTH-1:0]     r_dim_m, r_dim_n, r_out_m, r_out_n, r_oi, r_oj;
    logic [2:0]               r_k, r_ki, r_kj;
    logic [1:0]               r_stride;
    logic                     r_valid, r_signed, r_sat, r_error;
    logic [ADDR_WIDTH-1:0]    r_op1, r_op2, r_res;
    logic [CW-1:0]            r_kidx;
    logic [ACC_WIDTH-1:0]     r_acc;
    logic [ELEMENT_WIDTH-1:0] r_cache [CDEPTH];
    logic                     r_rd_en, r_wr_en;
    logic [ADDR_WIDTH-1:0]    r_rd_addr, r_wr_addr;
    logic [ELEMENT_WIDTH-1:0] r_wr_data;

    // ---------------- configuration check / output dimensions -------------
    logic                 w_cfg_err;
    logic [DIM_WIDTH-1:0] w_num_m, w_num_n, w_out_m, w_out_n;

    assign w_cfg_err = ~r_k[0] | (r_k > 3'(KMAX)) | (r_stride == 2'd0)
                     | (r_dim_m == '0) | (r_dim_n == '0)
                     | (r_valid & ((DIM_WIDTH'(r_k) > r_dim_m) | (DIM_WIDTH'(r_k) > r_dim_n)));
    assign w_num_m = r_valid ? r_dim_m - DIM_WIDTH'(r_k) : r_dim_m - DIM_WIDTH'(1);
    assign w_num_n = r_valid ? r_dim_n - DIM_WIDTH'(r_k) : r_dim_n - DIM_WIDTH'(1);
    assign w_out_m = w_num_m / DIM_WIDTH'(r_stride) + DIM_WIDTH'(1);
    assign w_out_n = w_num_n / DIM_WIDTH'(r_stride) + DIM_WIDTH'(1);

    // ---------------- tap coordinate and address --------------------------
    logic [2:0]            w_pad;
    logic [RW-1:0]         w_row, w_col;
    logic                  w_in_range;
    logic [ADDR_WIDTH-1:0] w_lin;
    logic [CW-1:0]         w_tap, w_kk_last;

    assign w_pad      = r_valid ? 3'd0 : (r_k >> 1);
    assign w_row      = RW'(r_oi) * RW'(r_stride) + RW'(r_ki) - RW'(w_pad);
    assign w_col      = RW'(r_oj) * RW'(r_stride) + RW'(r_kj) - RW'(w_pad);
    // MSB set means the coordinate went negative (inside the zero pad)
    assign w_in_range = ~w_row[RW-1] & ~w_col[RW-1]
                      & (w_row < RW'(r_dim_m)) & (w_col < RW'(r_dim_n));
    assign w_lin      = ADDR_WIDTH'(w_row[RW-2:0]) * ADDR_WIDTH'(r_dim_n)
                      + ADDR_WIDTH'(w_col[RW-2:0]);
    assign w_tap      = CW'(r_ki) * CW'(r_k) + CW'(r_kj);
    assign w_kk_last  = CW'(r_k) * CW'(r_k) - CW'(1);

    // ---------------- multiply / result shaping ---------------------------
    // Extend both operands to accumulator width first; the truncated product
    // is then correct modulo 2^ACC_WIDTH for either signedness.
    logic [ACC_WIDTH-1:0]     w_a_ext, w_w_ext, w_prod;
    logic [ELEMENT_WIDTH-1:0] w_weight, w_res;

    assign w_weight = r_cache[w_tap];
    assign w_a_ext  = {{(ACC_WIDTH-ELEMENT_WIDTH){r_signed & mem_rd_data[ELEMENT_WIDTH-1]}}, mem_rd_data};
    assign w_w_ext  = {{(ACC_WIDTH-ELEMENT_WIDTH){r_signed & w_weight[ELEMENT_WIDTH-1]}}, w_weight};
    assign w_prod   = w_a_ext * w_w_ext;

    always_comb begin
        w_res = r_acc[ELEMENT_WIDTH-1:0];
        if (r_sat) begin
            if (r_signed) begin
                if ($signed(r_acc) > $signed(c_SMAX))
                    w_res = c_SMAX[ELEMENT_WIDTH-1:0];
                else if ($signed(r_acc) < $signed(c_SMIN))
                    w_res = c_SMIN[ELEMENT_WIDTH-1:0];
            end else if (r_acc > c_UMAX) begin
                w_res = c_UMAX[ELEMENT_WIDTH-1:0];
            end
        end
    end

    // ---------------- control FSM -----------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_dim_m   <= '0;
            r_dim_n   <= '0;
            r_out_m   <= '0;
            r_out_n   <= '0;
            r_oi      <= '0;
            r_oj      <= '0;
            r_k       <= '0;
            r_ki      <= '0;
            r_kj      <= '0;
            r_stride  <= '0;
            r_valid   <= 1'b0;
            r_signed  <= 1'b0;
            r_sat     <= 1'b0;
            r_error   <= 1'b0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_res     <= '0;
            r_kidx    <= '0;
            r_acc     <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            for (int i = 0; i < CDEPTH; i++) r_cache[i] <= '0;
        end else begin
            // strobes are single-cycle unless re-asserted below
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_dim_m  <= dim_m;
                        r_dim_n  <= dim_n;
                        r_k      <= k_size;
                        r_stride <= stride;
                        r_valid  <= pad_valid;
                        r_signed <= signed_en;
                        r_sat    <= sat_en;
                        r_op1    <= addr_op1;
                        r_op2    <= addr_op2;
                        r_res    <= addr_res;
                        r_state  <= c_CHECK;
                    end
                end
                c_CHECK: begin
                    if (w_cfg_err) begin
                        r_error <= 1'b1;
                        r_out_m <= '0;
                        r_out_n <= '0;
                        r_state <= c_DONE;
                    end else begin
                        r_out_m   <= w_out_m;
                        r_out_n   <= w_out_n;
                        r_kidx    <= '0;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= r_op2;
                        r_state   <= c_LOAD_K;
                    end
                end
                c_LOAD_K: r_state <= c_WAIT_K;
                c_WAIT_K: begin
                    r_cache[r_kidx] <= mem_rd_data;
                    if (r_kidx == w_kk_last) begin
                        r_oi    <= '0;
                        r_oj    <= '0;
                        r_state <= c_PIX_INIT;
                    end else begin
                        r_kidx    <= r_kidx + CW'(1);
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= r_op2 + ADDR_WIDTH'(r_kidx) + ADDR_WIDTH'(1);
                        r_state   <= c_LOAD_K;
                    end
                end
                c_PIX_INIT: begin
                    r_acc   <= '0;
                    r_ki    <= '0;
                    r_kj    <= '0;
                    r_state <= c_TAP;
                end
                c_TAP: begin
                    if (w_in_range) begin
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= r_op1 + w_lin;
                        r_state   <= c_RD_WAIT;
                    end else begin
                        r_state <= c_NEXT_TAP;
                    end
                end
                c_RD_WAIT: r_state <= c_MAC;
                c_MAC: begin
                    r_acc   <= r_acc + w_prod;
                    r_state <= c_NEXT_TAP;
                end
                c_NEXT_TAP: begin
                    if (r_kj == r_k - 3'd1) begin
                        r_kj <= '0;
                        if (r_ki == r_k - 3'd1) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_res + ADDR_WIDTH'(r_oi) * ADDR_WIDTH'(r_out_n)
                                       + ADDR_WIDTH'(r_oj);
                            r_wr_data <= w_res;
                            r_state   <= c_WRITE;
                        end else begin
                            r_ki    <= r_ki + 3'd1;
                            r_state <= c_TAP;
                        end
                    end else begin
                        r_kj    <= r_kj + 3'd1;
                        r_state <= c_TAP;
                    end
                end
                c_WRITE: r_state <= c_NEXT_PIX;
                c_NEXT_PIX: begin
                    if (r_oj == r_out_n - DIM_WIDTH'(1)) begin
                        r_oj <= '0;
                        if (r_oi == r_out_m - DIM_WIDTH'(1)) begin
                            r_state <= c_DONE;
                        end else begin
                            r_oi    <= r_oi + DIM_WIDTH'(1);
                            r_state <= c_PIX_INIT;
                        end
                    end else begin
                        r_oj    <= r_oj + DIM_WIDTH'(1);
                        r_state <= c_PIX_INIT;
                    end
                end
                c_DONE: begin
                    if (!start) begin
                        r_error <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign done        = (r_state == c_DONE);
    assign busy        = (r_state != c_IDLE) && (r_state != c_DONE);
    assign error       = r_error;
    assign out_m       = r_out_m;
    assign out_n       = r_out_n;
    assign mem_rd_en   = r_rd_en;
    assign mem_rd_addr = r_rd_addr;
    assign mem_wr_en   = r_wr_en;
    assign mem_wr_addr = r_wr_addr;
    assign mem_wr_data = r_wr_data;

endmodule
`default_nettype wire
